// File: rtl/evr_event_decoder.sv
// Event receiver front end: link-lock FSM, event/dbus decode, seconds/ticks timestamp
// built from 0x70/0x71 shift events and the 0x7D seconds latch, plus an event-triggered latch.
module evr_event_decoder #(
  parameter int LOCK_WORDS    = 64,
  parameter int ERR_LIMIT     = 4,
  parameter int ERR_WINDOW    = 1024,
  parameter int COMMA_TIMEOUT = 4096
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_charisk,
  input  logic        rx_error,
  input  logic [7:0]  latch_event,
  output logic [7:0]  event_stream,
  output logic [7:0]  dbus,
  output logic        link_locked,
  output logic [31:0] ts_seconds,
  output logic [31:0] ts_ticks,
  output logic        ts_valid,
  output logic        ts_error,
  output logic [31:0] latched_seconds,
  output logic [31:0] latched_ticks,
  output logic        latch_strobe,
  output logic [15:0] err_count
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int GW = $clog2(LOCK_WORDS + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int CW = $clog2(COMMA_TIMEOUT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_WORDS - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(COMMA_TIMEOUT - 1);

  logic [1:0]    state;
  logic [GW-1:0] goodCnt;
  logic [WW-1:0] winCnt;
  logic [EW-1:0] winErr;
  logic [CW-1:0] commaGap;
  logic [31:0]   shiftReg;
  logic [5:0]    bitCnt;

  logic       locked, isComma, winEnd, loseLock, wordValid;
  logic [7:0] evt;

  assign locked      = (state == LOCKED);
  assign link_locked = locked;
  assign isComma     = rx_charisk[0] && (rx_data[7:0] == 8'hBC) && !rx_error;
  assign winEnd      = (winCnt == WIN_LAST);
  // Either loss condition kills this word's decode so outputs drop on the same edge.
  assign loseLock    = locked && ((rx_error && winErr == ERR_LAST) ||
                                  (!isComma && commaGap == GAP_LAST));
  assign wordValid   = locked && !rx_error && !rx_charisk[0] && !loseLock;
  assign evt         = wordValid ? rx_data[7:0] : 8'h00;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= HUNT;
      goodCnt         <= '0;
      winCnt          <= '0;
      winErr          <= '0;
      commaGap        <= '0;
      shiftReg        <= '0;
      bitCnt          <= '0;
      event_stream    <= '0;
      dbus            <= '0;
      ts_seconds      <= '0;
      ts_ticks        <= '0;
      ts_valid        <= 1'b0;
      ts_error        <= 1'b0;
      latched_seconds <= '0;
      latched_ticks   <= '0;
      latch_strobe    <= 1'b0;
      err_count       <= '0;
    end else begin
      event_stream <= evt;
      ts_error     <= 1'b0;
      latch_strobe <= 1'b0;
      if (locked && !rx_error && !rx_charisk[1]) dbus <= rx_data[15:8];
      if (rx_error && err_count != 16'hFFFF) err_count <= err_count + 16'd1;

      case (state)
        HUNT:    if (isComma) begin state <= CHECK; goodCnt <= '0; end
        CHECK:   if (rx_error) state <= HUNT;
                 else if (goodCnt == GOOD_LAST) state <= LOCKED;
                 else goodCnt <= goodCnt + GW'(1);
        LOCKED:  if (loseLock) state <= HUNT;
        default: state <= HUNT;
      endcase

      // Error window and comma gap only run while locked; they start fresh on each lock.
      if (!locked || loseLock) begin
        winCnt   <= '0;
        winErr   <= '0;
        commaGap <= '0;
      end else begin
        winCnt   <= winEnd ? '0 : winCnt + WW'(1);
        winErr   <= winEnd ? '0 : (rx_error ? winErr + EW'(1) : winErr);
        commaGap <= isComma ? '0 : commaGap + CW'(1);
      end

      if (loseLock) begin
        ts_valid <= 1'b0;
        shiftReg <= '0;
        bitCnt   <= '0;
      end else begin
        if (ts_valid) ts_ticks <= ts_ticks + 32'd1;
        if (evt == 8'h70 || evt == 8'h71) begin
          shiftReg <= {shiftReg[30:0], evt[0]};
          if (bitCnt != 6'd33) bitCnt <= bitCnt + 6'd1;
        end else if (evt == 8'h7D) begin
          shiftReg <= '0;
          bitCnt   <= '0;
          if (bitCnt == 6'd32) begin
            ts_seconds <= shiftReg;
            ts_ticks   <= '0;
            ts_valid   <= 1'b1;
          end else begin
            ts_error <= 1'b1;
          end
        end
      end

      // Captures pre-edge values, so latching on 0x7D records the time before reload.
      if (latch_event != 8'h00 && evt == latch_event) begin
        latched_seconds <= ts_seconds;
        latched_ticks   <= ts_ticks;
        latch_strobe    <= 1'b1;
      end
    end
  end

endmodule
